// File: rtl/uart_axi_pkg.sv
// uart_axi_pkg: register map, status bits and FSM states
// shared by the UART Lite AXI sequencer.
package uart_axi_pkg;

    localparam logic [31:0] RX_FIFO_OFS = 32'h0000_0000;
    localparam logic [31:0] TX_FIFO_OFS = 32'h0000_0004;
    localparam logic [31:0] STAT_OFS    = 32'h0000_0008;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef logic [3:0] state_t;

    localparam state_t IDLE    = 4'd0;
    localparam state_t POLL_AR = 4'd1;
    localparam state_t POLL_R  = 4'd2;
    localparam state_t GAP     = 4'd3;
    localparam state_t RD_AR   = 4'd4;
    localparam state_t RD_R    = 4'd5;
    localparam state_t WR_AW   = 4'd6;
    localparam state_t WR_B    = 4'd7;
    localparam state_t DONE    = 4'd8;

endpackage

// File: rtl/axi_lite_wr_chan.sv
// axi_lite_wr_chan: raises AW and W together, drops each on
// its own handshake, pulses done when the last one completes.
module axi_lite_wr_chan (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic awvalid,
    input  logic awready,
    output logic wvalid,
    input  logic wready,
    output logic done
);

    // Each valid is held until its own handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (start) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awvalid && awready)
                awvalid <= 1'b0;
            if (wvalid && wready)
                wvalid <= 1'b0;
        end
    end

    assign done = (awvalid || wvalid)
                && (!awvalid || awready)
                && (!wvalid || wready);

endmodule

// File: rtl/uart_axi_ctrl.sv
// uart_axi_ctrl: core byte-I/O to AXI UART Lite sequencer.
// Define AXI_ERR_CHECK_EN to flag non-OKAY AXI responses.
module uart_axi_ctrl
    import uart_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        err,
    output logic [31:0] s_axi_araddr,
    output logic        s_axi_arvalid,
    input  logic        s_axi_arready,
    input  logic [31:0] s_axi_rdata,
    input  logic [1:0]  s_axi_rresp,
    input  logic        s_axi_rvalid,
    output logic        s_axi_rready,
    output logic [31:0] s_axi_awaddr,
    output logic        s_axi_awvalid,
    input  logic        s_axi_awready,
    output logic [31:0] s_axi_wdata,
    output logic [3:0]  s_axi_wstrb,
    output logic        s_axi_wvalid,
    input  logic        s_axi_wready,
    input  logic [1:0]  s_axi_bresp,
    input  logic        s_axi_bvalid,
    output logic        s_axi_bready
);

    localparam logic [31:0] STAT_ADDR = BASE_ADDR + STAT_OFS;
    localparam logic [31:0] RX_ADDR   = BASE_ADDR + RX_FIFO_OFS;
    localparam logic [31:0] TX_ADDR   = BASE_ADDR + TX_FIFO_OFS;
    localparam logic [3:0]  GAP_LAST  = 4'(POLL_GAP - 1);
    localparam state_t POLL_NEXT = (POLL_GAP == 0) ? POLL_AR : GAP;

    state_t      state;
    logic        we_q;
    logic [7:0]  byte_q;
    logic [3:0]  gap_cnt;
    logic        err_q;
    logic        rd_err;
    logic        wr_err;
    logic        rd_hs;
    logic        b_hs;
    logic        wr_start;
    logic        wr_done;
    logic        unused_sink;

`ifdef AXI_ERR_CHECK_EN
    assign rd_err = (s_axi_rresp != AXI_OKAY);
    assign wr_err = (s_axi_bresp != AXI_OKAY);
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    assign unused_sink = ^{s_axi_rdata[31:8], s_axi_rresp, s_axi_bresp};

    assign rd_hs = s_axi_rvalid && s_axi_rready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

    assign req_ready     = (state == IDLE) && !rst;
    assign resp_valid    = (state == DONE);
    assign s_axi_arvalid = (state == POLL_AR) || (state == RD_AR);
    assign s_axi_araddr  = (state == POLL_AR) ? STAT_ADDR :
                           (state == RD_AR)   ? RX_ADDR   : 32'h0;
    assign s_axi_rready  = (state == POLL_R) || (state == RD_R);
    assign s_axi_awaddr  = (state == WR_AW) ? TX_ADDR : 32'h0;
    assign s_axi_wdata   = (state == WR_AW) ? {24'h0, byte_q} : 32'h0;
    assign s_axi_wstrb   = (state == WR_AW) ? 4'b0001 : 4'b0000;
    assign s_axi_bready  = (state == WR_B);
    assign err           = err_q;

    assign wr_start = (state == POLL_R) && s_axi_rvalid && we_q
                    && !s_axi_rdata[STAT_TX_FULL] && !rd_err;

    axi_lite_wr_chan u_wr_chan (
        .clk     (clk),
        .rst     (rst),
        .start   (wr_start),
        .awvalid (s_axi_awvalid),
        .awready (s_axi_awready),
        .wvalid  (s_axi_wvalid),
        .wready  (s_axi_wready),
        .done    (wr_done)
    );

    // Request sequencing: poll status, then one FIFO access
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            byte_q    <= 8'h00;
            gap_cnt   <= 4'h0;
            resp_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q   <= req_we;
                        byte_q <= req_wdata;
                        state  <= POLL_AR;
                    end
                end
                POLL_AR: begin
                    if (s_axi_arready)
                        state <= POLL_R;
                end
                POLL_R: begin
                    if (s_axi_rvalid) begin
                        gap_cnt <= 4'h0;
                        if (rd_err)
                            state <= POLL_NEXT;
                        else if (!we_q && s_axi_rdata[STAT_RX_VALID])
                            state <= RD_AR;
                        else if (we_q && !s_axi_rdata[STAT_TX_FULL])
                            state <= WR_AW;
                        else
                            state <= POLL_NEXT;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= POLL_AR;
                    else
                        gap_cnt <= gap_cnt + 4'h1;
                end
                RD_AR: begin
                    if (s_axi_arready)
                        state <= RD_R;
                end
                RD_R: begin
                    if (s_axi_rvalid) begin
                        resp_data <= rd_err ? 8'hFF : s_axi_rdata[7:0];
                        state     <= DONE;
                    end
                end
                WR_AW: begin
                    if (wr_done)
                        state <= WR_B;
                end
                WR_B: begin
                    if (s_axi_bvalid)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if ((rd_hs && rd_err) || (b_hs && wr_err))
            err_q <= 1'b1;
    end

endmodule

// File: tb/tb_uart_axi_ctrl.sv
// tb_uart_axi_ctrl: table-driven requests against an AXI UART
// Lite slave model, with a response scoreboard.
module tb_uart_axi_ctrl;

    localparam logic [31:0] STAT_A = 32'h8;
    localparam logic [31:0] RX_A   = 32'h0;
    localparam logic [31:0] TX_A   = 32'h4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_axi_ctrl #(
        .BASE_ADDR (32'h0000_0000),
        .POLL_GAP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .err           (err),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave configuration and logs
    int          busy_polls = 0;
    logic [7:0]  rx_byte = 8'h00;
    logic [1:0]  rx_resp = 2'b00;
    int          aw_delay = 0;
    int          n_stat = 0;
    int          n_rx = 0;
    int          n_aw = 0;
    int          n_w = 0;
    logic [31:0] last_awaddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;
    int          stat_cyc[$];

    bit          p_ar, p_r, p_aw, p_w, p_b, aw_got, w_got;
    logic [31:0] ar_q, aw_q, w_q;
    logic [3:0]  ws_q;
    int          aw_cnt = 0;

    // AXI UART Lite slave: decides at negedge what the next posedge does
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            if (p_r) rvalid = 1'b0;
            if (p_b) bvalid = 1'b0;
            if (p_ar) begin
                rvalid = 1'b1;
                if (ar_q == STAT_A) begin
                    n_stat++;
                    stat_cyc.push_back(cyc);
                    rdata = (busy_polls > 0) ? 32'h8 : 32'h1;
                    rresp = 2'b00;
                    if (busy_polls > 0) busy_polls--;
                end else begin
                    n_rx++;
                    rdata = {24'h0, rx_byte};
                    rresp = rx_resp;
                end
            end
            if (p_aw) begin
                n_aw++; last_awaddr = aw_q; aw_got = 1; aw_cnt = 0;
            end
            if (p_w) begin
                n_w++; last_wdata = w_q; last_wstrb = ws_q; w_got = 1;
            end
            if (aw_got && w_got) begin
                bvalid = 1'b1; bresp = 2'b00; aw_got = 0; w_got = 0;
            end
            if (rst) begin
                rvalid = 0; bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0;
            end
            arready = arvalid;
            wready = wvalid;
            if (awvalid && aw_cnt < aw_delay) begin
                awready = 1'b0;
                aw_cnt++;
            end else begin
                awready = awvalid;
            end
            p_ar = arvalid && arready; ar_q = araddr;
            p_r = rvalid && rready;
            p_aw = awvalid && awready; aw_q = awaddr;
            p_w = wvalid && wready; w_q = wdata; ws_q = wstrb;
            p_b = bvalid && bready;
        end
    end

    typedef struct {
        bit         chk;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int   n_resp = 0;
    int   resp_cyc = 0;
    int   n_awv = 0;
    int   n_wv = 0;
    int   n_bviol = 0;

    // response monitor and scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (awvalid) n_awv++;
            if (wvalid) n_wv++;
            if (bready && (awvalid || wvalid)) n_bviol++;
            if (resp_valid) begin
                n_resp++;
                resp_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid data %0h, expected no response",
                             resp_data);
                end else begin
                    sb_e = sb.pop_front();
                    if (sb_e.chk) chk("resp_data", {24'h0, resp_data}, {24'h0, sb_e.d});
                end
            end
        end
    end

    int acc_cyc = 0;

    task automatic do_req(input bit we, input logic [7:0] d);
        int n = 0;
        req_we = we;
        req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("req_accept_timeout", {31'h0, req_ready}, 1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, input string name);
        int n = 0;
        while (n_resp < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n_resp < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d responses, required %0d", name, n_resp, target);
        end
    endtask

    typedef struct {
        bit         we;
        logic [7:0] wd;
        logic [7:0] rx;
        int         busy;
        int         e_stat;
        int         e_rx;
        int         e_aw;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[5];
    int   start;
    int   r1;
    int   acc_c[2];
    int   acc;
    int   rc;
    int   n;
    bit   exp_err;
    logic [7:0] exp_ed;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_wdata = 8'h00;

        vecs[0] = '{1'b0, 8'h00, 8'h41, 0, 1, 1, 0, 8'h41};
        vecs[1] = '{1'b1, 8'h5A, 8'h00, 3, 4, 0, 1, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 8'hC3, 2, 3, 1, 0, 8'hC3};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 0, 1, 0, 1, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1, 2, 1, 0, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_ctrl",
            {12'h0, req_ready, resp_valid, arvalid, rready, awvalid,
             wvalid, bready, err, resp_data, wstrb}, 32'h0);
        chk("reset_addr", araddr | awaddr | wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'h0, req_ready}, 1);

        for (int i = 0; i < 5; i++) begin
            busy_polls = vecs[i].busy;
            rx_byte = vecs[i].rx;
            n_stat = 0; n_rx = 0; n_aw = 0; n_w = 0;
            stat_cyc.delete();
            sb.push_back('{chk: !vecs[i].we, d: vecs[i].e_data});
            start = n_resp;
            do_req(vecs[i].we, vecs[i].wd);
            wait_resp(start + 1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_stat_reads", i), n_stat, vecs[i].e_stat);
            chk($sformatf("vec%0d_rx_reads", i), n_rx, vecs[i].e_rx);
            chk($sformatf("vec%0d_aw_count", i), n_aw, vecs[i].e_aw);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_awaddr", i), last_awaddr, TX_A);
                chk($sformatf("vec%0d_wdata", i), last_wdata, {24'h0, vecs[i].wd});
                chk($sformatf("vec%0d_wstrb", i), {28'h0, last_wstrb}, 1);
                chk($sformatf("vec%0d_resp_data_hold", i),
                    {24'h0, resp_data}, {24'h0, vecs[i-1].e_data});
            end
            for (int k = 1; k < stat_cyc.size(); k++)
                chk($sformatf("vec%0d_poll_gap", i), stat_cyc[k] - stat_cyc[k-1], 6);
            if (i == 0) chk("read_latency", resp_cyc - acc_cyc + 1, 6);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, 0);
            @(negedge clk);
        end

        // slow AWREADY, immediate WREADY
        aw_delay = 2;
        busy_polls = 0;
        n_aw = 0;
        sb.push_back('{chk: 1'b0, d: 8'h00});
        start = n_resp;
        n_awv = 0; n_wv = 0; n_bviol = 0;
        do_req(1'b1, 8'h33);
        wait_resp(start + 1, "slow_aw");
        chk("slow_aw_awvalid_cycles", n_awv, 3);
        chk("slow_aw_wvalid_cycles", n_wv, 1);
        chk("slow_aw_bready_early", n_bviol, 0);
        chk("slow_aw_aw_count", n_aw, 1);
        chk("slow_aw_wdata", last_wdata, 32'h33);
        aw_delay = 0;
        @(negedge clk);

        // reset while in RD_R with read data pending
        rx_byte = 8'h99;
        start = n_resp;
        do_req(1'b0, 8'h00);
        rc = 0;
        n = 0;
        while (rc < 2 && n < 50) begin
            if (rready) rc++;
            if (rc < 2) @(negedge clk);
            n++;
        end
        chk("rst_reach_rd_r", rc, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl",
            {20'h0, req_ready, resp_valid, arvalid, rready, awvalid,
             wvalid, bready, err, wstrb}, 32'h0);
        chk("rst_mid_addr", araddr | awaddr | wdata, 32'h0);
        chk("rst_mid_resp_data", {24'h0, resp_data}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {31'h0, req_ready}, 1);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_resp", n_resp - start, 0);

        // back-to-back reads with req_valid held
        rx_byte = 8'h77;
        sb.push_back('{chk: 1'b1, d: 8'h77});
        sb.push_back('{chk: 1'b1, d: 8'h77});
        start = n_resp;
        req_we = 1'b0;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 100 && acc < 2; i++) begin
            if (req_ready) begin
                acc_c[acc] = cyc;
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        r1 = resp_cyc;
        chk("b2b_accepts", acc, 2);
        chk("b2b_accept_after_resp", acc_c[1] - r1, 1);
        wait_resp(start + 2, "b2b");
        repeat (10) @(negedge clk);
        chk("b2b_resp_count", n_resp - start, 2);
        chk("b2b_sb_empty", sb.size(), 0);

        // error response on the RX FIFO read
`ifdef AXI_ERR_CHECK_EN
        exp_err = 1'b1;
        exp_ed = 8'hFF;
`else
        exp_err = 1'b0;
        exp_ed = 8'h41;
`endif
        rx_byte = 8'h41;
        rx_resp = 2'b10;
        sb.push_back('{chk: 1'b1, d: exp_ed});
        start = n_resp;
        do_req(1'b0, 8'h00);
        wait_resp(start + 1, "rd_err");
        chk("rd_err_flag", {31'h0, err}, {31'h0, exp_err});
        rx_resp = 2'b00;
        rx_byte = 8'h12;
        sb.push_back('{chk: 1'b1, d: 8'h12});
        start = n_resp;
        do_req(1'b0, 8'h00);
        wait_resp(start + 1, "err_sticky");
        chk("err_sticky", {31'h0, err}, {31'h0, exp_err});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_rst", {31'h0, err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
